// File: rtl/mbist_pkg.sv
// mbist_pkg: March C- element table and controller state encoding.
package mbist_pkg;
    localparam int MARCH_NUM_ELEM = 6;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    typedef struct packed {
        logic       down;
        logic       two;
        logic [1:0] rd;
        logic [1:0] val;
    } march_elem_t;
    // bit [i] of rd/val describes op i of the element: read-vs-write and background
    function automatic march_elem_t march_elem(input logic [2:0] e);
        case (e)
            3'd0:    march_elem = '{down: 1'b0, two: 1'b0, rd: 2'b00, val: 2'b00};
            3'd1:    march_elem = '{down: 1'b0, two: 1'b1, rd: 2'b01, val: 2'b10};
            3'd2:    march_elem = '{down: 1'b0, two: 1'b1, rd: 2'b01, val: 2'b01};
            3'd3:    march_elem = '{down: 1'b1, two: 1'b1, rd: 2'b01, val: 2'b10};
            3'd4:    march_elem = '{down: 1'b1, two: 1'b1, rd: 2'b01, val: 2'b01};
            default: march_elem = '{down: 1'b0, two: 1'b0, rd: 2'b01, val: 2'b00};
        endcase
    endfunction
endpackage

// File: rtl/mbist_march_ctrl_if.sv
// mbist_mem_if: single-port sync SRAM request/response bundle.
interface mbist_mem_if #(parameter int pADDR_WIDTH = 4, parameter int pDATA_WIDTH = 2);
    logic                   cs;
    logic                   we;
    logic [pADDR_WIDTH-1:0] addr;
    logic [pDATA_WIDTH-1:0] din;
    logic [pDATA_WIDTH-1:0] dout;
    modport master (output cs, we, addr, din, input dout);
    modport slave  (input cs, we, addr, din, output dout);
endinterface

// File: rtl/mbist_addr_gen.sv
// mbist_addr_gen: up/down address counter with start-address load and terminal flag.
module mbist_addr_gen #(parameter int pADDR_WIDTH = 4) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   load_down,
    input  logic                   step,
    input  logic                   down,
    output logic [pADDR_WIDTH-1:0] addr,
    output logic                   last
);
    assign last = down ? (addr == '0) : (&addr);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) addr <= '0;
        else if (load) addr <= load_down ? '1 : '0;
        else if (step) addr <= down ? addr - 1'b1 : addr + 1'b1;
    end
endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- BIST controller owning the SRAM port while testing,
// passing functional traffic through when idle, with first-fail capture.
module mbist_march_ctrl #(
    parameter int pADDR_WIDTH = 4,
    parameter int pDATA_WIDTH = 2,
    parameter int pFCNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [pFCNT_WIDTH-1:0] fail_cnt,
    output logic [pADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]             fail_elem,
    output logic [pDATA_WIDTH-1:0] fail_exp,
    output logic [pDATA_WIDTH-1:0] fail_act,
    mbist_mem_if.slave             sys,
    mbist_mem_if.master            mem
);
    import mbist_pkg::*;
    state_t                 state;
    logic [2:0]             elem, elem_nxt, op_elem, p_elem;
    logic                   opi, ag_last, accept, issue, last_op, elem_end, run_end, miscmp;
    logic                   op_cs, op_we, op_last, p_valid;
    logic [pADDR_WIDTH-1:0] addr, op_addr, p_addr;
    logic [pDATA_WIDTH-1:0] op_din, p_exp;
    march_elem_t            me, me_nxt;
    assign me       = march_elem(elem);
    assign accept   = start & (state == IDLE || state == DONE);
    assign issue    = accept | (state == RUN & ~op_last);
    assign last_op  = ~me.two | opi;
    assign elem_end = last_op & ag_last;
    assign run_end  = elem_end & (elem == 3'(MARCH_NUM_ELEM - 1));
    assign elem_nxt = run_end ? 3'd0 : elem + 3'd1;
    assign me_nxt   = march_elem(elem_nxt);
    assign miscmp   = p_valid & (mem.dout != p_exp);
    assign mem.cs   = busy ? op_cs : sys.cs;
    assign mem.we   = busy ? op_we : sys.we;
    assign mem.addr = busy ? op_addr : sys.addr;
    assign mem.din  = busy ? op_din : sys.din;
    assign sys.dout = mem.dout;
    mbist_addr_gen #(.pADDR_WIDTH(pADDR_WIDTH)) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (issue & elem_end),
        .load_down(me_nxt.down),
        .step     (issue & last_op & ~ag_last),
        .down     (me.down),
        .addr     (addr),
        .last     (ag_last)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_cnt  <= '0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
            elem      <= '0;
            opi       <= 1'b0;
            op_cs     <= 1'b0;
            op_we     <= 1'b0;
            op_last   <= 1'b0;
            op_addr   <= '0;
            op_din    <= '0;
            op_elem   <= '0;
            p_valid   <= 1'b0;
            p_exp     <= '0;
            p_addr    <= '0;
            p_elem    <= '0;
        end else begin
            op_cs   <= issue;
            op_we   <= issue & ~me.rd[opi];
            op_addr <= addr;
            op_din  <= {pDATA_WIDTH{me.val[opi]}};
            op_elem <= elem;
            op_last <= issue & run_end;
            // read data is registered in the SRAM, so the compare lags the read by one edge
            p_valid <= op_cs & ~op_we;
            p_exp   <= op_din;
            p_addr  <= op_addr;
            p_elem  <= op_elem;
            if (issue) begin
                elem <= elem_end ? elem_nxt : elem;
                opi  <= ~last_op;
            end
            if (accept) begin
                state     <= RUN;
                busy      <= 1'b1;
                done      <= 1'b0;
                fail      <= 1'b0;
                fail_cnt  <= '0;
                fail_addr <= '0;
                fail_elem <= '0;
                fail_exp  <= '0;
                fail_act  <= '0;
            end else if (state == RUN && op_last) begin
                state <= DRAIN;
            end else if (state == DRAIN) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
            if (miscmp) begin
                fail     <= 1'b1;
                fail_cnt <= fail_cnt + {{(pFCNT_WIDTH-1){1'b0}}, ~&fail_cnt};
                if (!fail) begin
                    fail_addr <= p_addr;
                    fail_elem <= p_elem;
                    fail_exp  <= p_exp;
                    fail_act  <= mem.dout;
                end
            end
        end
    end
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: directed bench with an SRAM model, op-sequence and status scoreboards.
module tb_mbist_march_ctrl;
    localparam int AW = 4;
    localparam int DW = 2;
    localparam int N  = 16;
    typedef struct packed {
        logic          f;
        logic [7:0]    cnt;
        logic [AW-1:0] a;
        logic [2:0]    e;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
    } status_t;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic busy, done, fail;
    logic [7:0]    fail_cnt;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [DW-1:0] fail_exp, fail_act;
    int nchk = 0, npass = 0, nfail = 0;
    logic [DW-1:0] ram [N];
    logic          fault_en = 1'b0;
    logic [AW-1:0] fault_addr = '0;
    logic [DW-1:0] fault_val = '0;
    status_t       st_q [$];
    logic [7:0]    op_q [$];
    logic [DW-1:0] rd_q [$];
    // op codes: 0=r0 1=r1 2=w0 3=w1, -1 = no op
    int ops_tab [6][2] = '{'{2, -1}, '{0, 3}, '{1, 2}, '{0, 3}, '{1, 2}, '{0, -1}};
    bit dn_tab [6] = '{0, 0, 0, 1, 1, 0};
    mbist_mem_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) sys_if ();
    mbist_mem_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) mem_if ();
    mbist_march_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pFCNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .fail(fail),
        .fail_cnt(fail_cnt), .fail_addr(fail_addr), .fail_elem(fail_elem),
        .fail_exp(fail_exp), .fail_act(fail_act), .sys(sys_if.slave), .mem(mem_if.master)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (mem_if.cs) begin
            if (mem_if.we) ram[mem_if.addr] <= mem_if.din;
            else mem_if.dout <= (fault_en && mem_if.addr == fault_addr) ? fault_val : ram[mem_if.addr];
        end
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic sys_drive(input logic cs, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        sys_if.cs = cs;
        sys_if.we = we;
        sys_if.addr = a;
        sys_if.din = d;
    endtask
    task automatic push_ops();
        for (int e = 0; e < 6; e++)
            for (int i = 0; i < N; i++)
                for (int o = 0; o < 2; o++)
                    if (ops_tab[e][o] >= 0)
                        op_q.push_back({1'b1, ops_tab[e][o] >= 2, 4'(dn_tab[e] ? N - 1 - i : i),
                                        (ops_tab[e][o] % 2 == 1) ? 2'b11 : 2'b00});
    endtask
    task automatic run(input status_t exp_st, input bit hold, input int abort_at);
        status_t s;
        op_q.delete();
        push_ops();
        if (abort_at < 0) st_q.push_back(exp_st);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = hold;
        sys_drive(1'b1, 1'b1, 4'd7, 2'b01);
        check("busy_on", busy, 1);
        check("start_clr", {done, fail, fail_cnt, fail_addr, fail_elem, fail_exp, fail_act}, 0);
        for (int k = 0; k < 10 * N; k++) begin
            if (k > 0) @(negedge clk);
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                check("rst_flags", {busy, done, fail}, 0);
                check("rst_mux", {mem_if.cs, mem_if.we, mem_if.addr, mem_if.din}, {1'b1, 1'b1, 4'd7, 2'b01});
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                sys_drive(1'b0, 1'b0, 4'd0, 2'b00);
                return;
            end
            check($sformatf("op%0d", k), {mem_if.cs, mem_if.we, mem_if.addr, mem_if.din}, op_q.pop_front());
        end
        @(negedge clk);
        check("drain", {busy, done}, 2'b10);
        @(negedge clk);
        check("done", {busy, done}, 2'b01);
        s = st_q.pop_front();
        check("fail", fail, s.f);
        check("fail_cnt", fail_cnt, s.cnt);
        check("fail_addr", fail_addr, s.a);
        check("fail_elem", fail_elem, s.e);
        check("fail_exp", fail_exp, s.x);
        check("fail_act", fail_act, s.y);
        start = 1'b0;
        sys_drive(1'b0, 1'b0, 4'd0, 2'b00);
    endtask
    initial begin
        sys_drive(1'b0, 1'b0, 4'd0, 2'b00);
        repeat (2) @(negedge clk);
        check("reset", {busy, done, fail, fail_cnt, fail_addr, fail_elem, fail_exp, fail_act}, 0);
        rst = 1'b0;
        @(negedge clk);
        sys_drive(1'b1, 1'b1, 4'd3, 2'b01);
        #1;
        check("idle_mux", {mem_if.cs, mem_if.we, mem_if.addr, mem_if.din}, {1'b1, 1'b1, 4'd3, 2'b01});
        @(negedge clk);
        sys_drive(1'b1, 1'b0, 4'd3, 2'b00);
        rd_q.push_back(2'b01);
        @(negedge clk);
        sys_drive(1'b0, 1'b0, 4'd0, 2'b00);
        check("sys_dout", sys_if.dout, rd_q.pop_front());
        run('0, 1'b0, -1);
        @(negedge clk);
        sys_drive(1'b1, 1'b0, 4'd10, 2'b10);
        #1;
        check("post_mux", {mem_if.cs, mem_if.we, mem_if.addr, mem_if.din}, {1'b1, 1'b0, 4'd10, 2'b10});
        rd_q.push_back(2'b00);
        @(negedge clk);
        sys_drive(1'b0, 1'b0, 4'd0, 2'b00);
        check("post_dout", sys_if.dout, rd_q.pop_front());
        fault_en = 1'b1;
        fault_addr = 4'd5;
        fault_val = 2'b10;
        run('{1'b1, 8'd5, 4'd5, 3'd1, 2'b00, 2'b10}, 1'b0, -1);
        fault_en = 1'b0;
        run('0, 1'b1, -1);
        fault_en = 1'b1;
        fault_addr = 4'd9;
        fault_val = 2'b11;
        run('{1'b1, 8'd3, 4'd9, 3'd1, 2'b00, 2'b11}, 1'b0, -1);
        fault_en = 1'b0;
        run('0, 1'b0, 80);
        run('0, 1'b0, -1);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
